// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto a single shared memory port
//
// Purpose:
//   Grants either the instruction-fetch port or the data port onto one memory
//   port, holds the latched operands on mem_* for the whole access, and returns
//   the result with a one-cycle ready pulse. Each access is bounded by a wait
//   counter; on expiry the access completes with zero read data and err=1.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  defined   : alternate between ports on simultaneous requests
//                       undefined : fixed priority, data port always wins a tie
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_req, if_addr                 fetch request and address
//   if_ready, if_rdata              fetch completion pulse and fetched word
//   d_req, d_we, d_addr, d_wdata    data request (d_we=1 store, 0 load)
//   d_ready, d_rdata                data completion pulse and load data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                       shared memory port request side
//   mem_ack, mem_rdata              memory completion and read data
//   busy                            arbiter not idle
//   err                             timeout flag, coincident with the ready pulse

module mem_port_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  // TIMEOUT is limited to 2..255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              we_q, we_d;
  logic              served_data_q, served_data_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              gnt_data, gnt_fetch;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_data_q=1 means the data port wins the next tie; reset favours data.
  logic rr_data_q, rr_data_d;

  always_comb begin
    rr_data_d = rr_data_q;
    if (state_q == IDLE && (gnt_data || gnt_fetch)) begin
      rr_data_d = gnt_fetch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_data_q <= 1'b1;
    end else begin
      rr_data_q <= rr_data_d;
    end
  end

  assign gnt_data = d_req && (!if_req || rr_data_q);
`else
  assign gnt_data = d_req;
`endif

  assign gnt_fetch = if_req && !gnt_data;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    we_d          = we_q;
    served_data_d = served_data_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_data) begin
          state_d       = BUSY_D;
          addr_d        = d_addr;
          wdata_d       = d_wdata;
          we_d          = d_we;
          served_data_d = 1'b1;
          timeout_d     = 1'b0;
          cnt_d         = 8'd0;
        end else if (gnt_fetch) begin
          state_d       = BUSY_I;
          addr_d        = if_addr;
          wdata_d       = '0;
          we_d          = 1'b0;
          served_data_d = 1'b0;
          timeout_d     = 1'b0;
          cnt_d         = 8'd0;
        end
      end

      BUSY_I, BUSY_D: begin
        // An ack arriving on the limit cycle wins over the timeout.
        if (mem_ack) begin
          state_d   = DONE;
          timeout_d = 1'b0;
          if (!served_data_q) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          if (served_data_q) begin
            d_rdata_d = '0;
          end else begin
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      served_data_q <= 1'b0;
      timeout_q     <= 1'b0;
      cnt_q         <= 8'd0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      served_data_q <= served_data_d;
      timeout_q     <= timeout_d;
      cnt_q         <= cnt_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_we    = (state_q == BUSY_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_ready  = (state_q == DONE) && !served_data_q;
  assign d_ready   = (state_q == DONE) && served_data_q;
  assign err       = (state_q == DONE) && timeout_q;
  assign busy      = (state_q != IDLE);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int NOACK = 1000;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        err;

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    int          delay;
    int          exp_lat;
    int          exp_mr;
    logic        exp_err;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  rsp_t rsp_q[$];
  mtx_t mtx_q[$];
  vec_t vecs[8];

  int          tests = 0;
  int          fails = 0;
  int          ack_delay = NOACK;
  logic [31:0] cur_mem_data = 32'h0;
  logic        force_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay cycles of mem_req and checks the
  // transaction against the expected-access queue.
  initial begin
    int   wcnt;
    mtx_t m;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
      end else if (mem_req && ack_delay != NOACK && wcnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = cur_mem_data;
        wcnt      = 0;
        if (mtx_q.size() == 0) begin
          check("mem_unexpected_access", 32'd1, 32'd0);
        end else begin
          m = mtx_q.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (mem_req) wcnt++;
        else wcnt = 0;
      end
    end
  end

  // Response monitor: every ready pulse pops one expected completion.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        check("ready_exclusive", {31'd0, if_ready && d_ready}, 32'd0);
        if (rsp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("ready_port", {31'd0, d_ready}, {31'd0, r.is_d});
          check("ready_rdata", d_ready ? d_rdata : if_rdata, r.rdata);
          check("ready_err", {31'd0, err}, {31'd0, r.err});
        end
      end else if (err) begin
        check("err_without_ready", 32'd1, 32'd0);
      end
    end
  end

  task automatic push_access(input logic is_d, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic err_exp, input logic acked);
    mtx_t m;
    rsp_t r;
    if (acked) begin
      m.we = we; m.addr = addr; m.wdata = wdata;
      mtx_q.push_back(m);
    end
    r.is_d = is_d; r.rdata = rdata; r.err = err_exp;
    rsp_q.push_back(r);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int mr;
    logic got;
    ack_delay    = v.delay;
    cur_mem_data = v.mem_data;
    push_access(v.is_d, v.is_d && v.we, v.addr, v.wdata,
                v.is_d ? v.exp_d : v.exp_if, v.exp_err, v.delay != NOACK);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    cyc = 0; mr = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (mem_req) mr++;
      if (if_ready || d_ready) got = 1'b1;
    end
    check($sformatf("v%0d_ready_seen", idx), {31'd0, got}, 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
    check($sformatf("v%0d_mem_req_cycles", idx), 32'(mr), 32'(v.exp_mr));
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_if_rdata_hold", idx), if_rdata, v.exp_if);
    check($sformatf("v%0d_d_rdata_hold", idx), d_rdata, v.exp_d);
    check($sformatf("v%0d_idle", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int nrdy;

    //          is_d  we    addr          wdata         mem_data      delay  lat mr err   exp_if        exp_d
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1,     3, 2, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 0,     2, 1, 1'b0, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,        32'hCAFE_F00D, 0,     2, 1, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0084, 32'hA5A5_A5A5, 32'h1111_1111, 2,     4, 3, 1'b0, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 3,     5, 4, 1'b0, 32'h1357_9BDF, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0088, 32'h0,        32'h7777_7777, NOACK, 5, 4, 1'b1, 32'h1357_9BDF, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        32'h7777_7777, NOACK, 5, 4, 1'b1, 32'h0,        32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_010C, 32'h0,        32'h2468_ACE0, 0,     2, 1, 1'b0, 32'h2468_ACE0, 32'h0};

    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Operands changed after the grant must not reach the memory port.
    ack_delay = 2;
    push_access(1'b1, 1'b1, 32'h0000_0500, 32'h5555_AAAA, 32'h0, 1'b0, 1'b1);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h5555_AAAA;
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h0000_0999; d_wdata = 32'h0;
    cyc = 0;
    while (!d_ready && cyc < 20) begin @(negedge clk); cyc++; end
    check("change_after_grant_done", {31'd0, d_ready}, 32'd1);
    d_req = 1'b0;
    @(negedge clk);

    // mem_ack while idle is ignored.
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_ack_busy", {31'd0, busy}, 32'd0);
    end
    force_ack = 1'b0;
    @(negedge clk);

    // Reset in the middle of a fetch: idle next cycle, no ready pulse.
    ack_delay = NOACK;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    @(negedge clk);
    check("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Simultaneous requests held across two completions.
    ack_delay = 0; cur_mem_data = 32'h0BAD_F00D;
    push_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    push_access(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
`else
    push_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
`endif
    if_req = 1'b1; if_addr = 32'h0000_0300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
    cyc = 0; nrdy = 0;
    while (nrdy < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (if_ready || d_ready) nrdy++;
    end
    check("b2b_two_completions", 32'(nrdy), 32'd2);
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mtx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the address, write data and read data buses.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for mem_ack per access (legal range 2..255).
REQ-003 SHALL have ports clk, input, 1, clock; reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports if_req, input, 1, instruction-fetch request; if_addr, input, DATA_W, fetch address.
REQ-005 SHALL have ports if_ready, output, 1, fetch complete pulse; if_rdata, output, DATA_W, fetched word.
REQ-006 SHALL have ports d_req, input, 1, data request; d_we, input, 1, 1=store, 0=load.
REQ-007 SHALL have ports d_addr, input, DATA_W, data address; d_wdata, input, DATA_W, store data.
REQ-008 SHALL have ports d_ready, output, 1, data complete pulse; d_rdata, output, DATA_W, load data.
REQ-009 SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, DATA_W; mem_wdata, output, DATA_W (single shared memory port).
REQ-010 SHALL have ports mem_ack, input, 1, access done; mem_rdata, input, DATA_W, read data valid with mem_ack.
REQ-011 SHALL have ports busy, output, 1, FSM not IDLE; err, output, 1, timeout pulse co-incident with the requester's ready.

Function
REQ-012 SHALL implement states IDLE, BUSY_I, BUSY_D, DONE.
REQ-013 IDLE: when a requester is granted, SHALL latch that requester's address/we/wdata into registers and enter BUSY_I or BUSY_D on the next edge; with no request, SHALL stay in IDLE.
REQ-014 SHALL drive mem_req=1 and all mem_* outputs from the latched registers throughout BUSY_I/BUSY_D; for fetches, mem_we SHALL be 0.
REQ-015 BUSY_x: on mem_ack=1, SHALL capture mem_rdata (loads and fetches only; 0 for stores) and enter DONE.
REQ-016 DONE: SHALL assert exactly one of if_ready or d_ready for exactly one cycle, matching the served requester, then return to IDLE.
REQ-017 if_rdata/d_rdata SHALL hold the last captured value until the next completion for that port.
REQ-018 Minimum latency SHALL be req sampled in cycle N, mem_req in N+1, ack in N+1, ready in N+2.
REQ-019 Requesters SHALL hold req and operands stable until ready; changes after the grant SHALL be ignored.
REQ-020 A request still high in the cycle after its ready (IDLE) SHALL be treated as a new request.
REQ-021 A wait counter SHALL clear on entry to BUSY_x and increment each cycle without mem_ack.
REQ-022 When the counter reaches TIMEOUT-1 without ack, SHALL enter DONE with rdata=0 and err=1 for that DONE cycle.
REQ-023 A mem_ack in the same cycle as the limit SHALL take precedence: normal completion, err=0.
REQ-024 mem_ack received outside BUSY_I/BUSY_D SHALL be ignored.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 When reset=1 at a clock edge, state SHALL become IDLE from any state, including mid-access.
REQ-027 On reset, mem_req, if_ready, d_ready, err and busy SHALL be 0; the counter, rdata registers and latched operands SHALL be 0; the round-robin pointer SHALL point to data.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-029 Macro undefined: fixed priority; with d_req and if_req both 1 in IDLE, data SHALL always be granted.
REQ-030 Macro defined: a 1-bit last-grant pointer SHALL update on every grant; on simultaneous requests, the port not granted last SHALL win; a single requester SHALL always be granted.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x100, mem_ack one cycle later with 0xDEADBEEF -> mem_req for 2 cycles, if_ready pulse, if_rdata=0xDEADBEEF.
REQ-032 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x40, mem_wdata=0x12345678, d_ready pulse, d_rdata unchanged.
REQ-033 Simultaneous if_req and d_req for 2 back-to-back accesses -> macro undefined: D then D; macro defined: D then I.
REQ-034 TIMEOUT=4 with mem_ack never asserted -> mem_req high 4 cycles, then d_ready=1 and err=1 in the same cycle, d_rdata=0.
REQ-035 Reset asserted in BUSY_I -> next cycle IDLE, mem_req=0, busy=0, no if_ready pulse.
